// File: rtl/spi_mstr_arb.sv
// Round-robin arbiter / transaction sequencer sharing one SPI master among
// up to four requesters.
//   clk, rst           : system clock, synchronous active-high reset
//   req/req_data/...   : per-requester level request, 16-bit word, frame
//                        width (1 = 8-bit) and edge select
//   ack / err          : one-cycle completion / timeout pulse to served requester
//   busy, cur_id       : arbiter not idle, index of requester being served
//   mstr_*             : start strobe and frame setup to SPI master; done back
module spi_mstr_arb #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned GAP_CYCLES = 8,
    parameter int unsigned TIMEOUT    = 4095
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]      req_width8,
    input  logic [NREQ-1:0]      req_pos_edge,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      err,
    output logic                 busy,
    output logic [1:0]           cur_id,
    output logic                 mstr_wrt,
    output logic [15:0]          mstr_data_out,
    output logic                 mstr_width8,
    output logic                 mstr_pos_edge,
    input  logic                 mstr_done
);

    localparam int unsigned WD_W  = 12;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_GAP
    } state_t;

    state_t            state, state_d;
    logic [1:0]        last, last_d;
    logic [1:0]        cur_id_d;
    logic [15:0]       data_d;
    logic              w8_d, pos_d, wrt_d, busy_d;
    logic [NREQ-1:0]   ack_d, err_d;
    logic [WD_W-1:0]   wdog, wdog_d, wdog_inc;
    logic [GAP_W-1:0]  gap_cnt, gap_d;
    logic              done_q, done_rise, gap_last;

    // winner of the rotating search and its request payload
    logic              win_found;
    logic [1:0]        win_id, idx;
    logic [15:0]       win_data;
    logic              win_w8, win_pos;
    logic [NREQ-1:0]   cur_oh;

    // done is edge-detected in every state so a level held across IDLE cannot fire late
    assign done_rise = mstr_done & ~done_q;
    assign wdog_inc  = wdog + WD_W'(1);
    assign gap_last  = (32'(gap_cnt) + 32'd1) >= GAP_CYCLES;

    // first set request searching upward from last+1 with wrap
    always_comb begin
        win_found = 1'b0;
        win_id    = last;
        win_data  = '0;
        win_w8    = 1'b0;
        win_pos   = 1'b0;
        idx       = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = 2'((32'(last) + off) % NREQ);
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (!win_found && (idx == 2'(k)) && req[k]) begin
                    win_found = 1'b1;
                    win_id    = 2'(k);
                    win_data  = req_data[16*k +: 16];
                    win_w8    = req_width8[k];
                    win_pos   = req_pos_edge[k];
                end
            end
        end
    end

    // one-hot of the requester being served, for ack/err
    always_comb begin
        cur_oh = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cur_oh[k] = (cur_id == 2'(k));
        end
    end

    // next-state and next-output logic
    always_comb begin
        state_d  = state;
        last_d   = last;
        cur_id_d = cur_id;
        data_d   = mstr_data_out;
        w8_d     = mstr_width8;
        pos_d    = mstr_pos_edge;
        wrt_d    = 1'b0;
        ack_d    = '0;
        err_d    = '0;
        wdog_d   = wdog;
        gap_d    = gap_cnt;

        case (state)
            S_IDLE: begin
                if (win_found) begin
                    state_d  = S_ISSUE;
                    cur_id_d = win_id;
                    data_d   = win_data;
                    w8_d     = win_w8;
                    pos_d    = win_pos;
                    wrt_d    = 1'b1;
                end
            end
            S_ISSUE: begin
                wdog_d  = '0;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                wdog_d = wdog_inc;
                // done has priority over a watchdog expiring in the same cycle
                if (done_rise) begin
                    ack_d   = cur_oh;
                    last_d  = cur_id;
                    gap_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end else if (wdog_inc == WD_W'(TIMEOUT)) begin
                    err_d   = cur_oh;
                    last_d  = cur_id;
                    gap_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (gap_last) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_cnt + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            last          <= 2'(NREQ - 1);
            cur_id        <= '0;
            mstr_data_out <= '0;
            mstr_width8   <= 1'b0;
            mstr_pos_edge <= 1'b0;
            mstr_wrt      <= 1'b0;
            ack           <= '0;
            err           <= '0;
            busy          <= 1'b0;
            wdog          <= '0;
            gap_cnt       <= '0;
            done_q        <= 1'b0;
        end else begin
            state         <= state_d;
            last          <= last_d;
            cur_id        <= cur_id_d;
            mstr_data_out <= data_d;
            mstr_width8   <= w8_d;
            mstr_pos_edge <= pos_d;
            mstr_wrt      <= wrt_d;
            ack           <= ack_d;
            err           <= err_d;
            busy          <= busy_d;
            wdog          <= wdog_d;
            gap_cnt       <= gap_d;
            done_q        <= mstr_done;
        end
    end

endmodule
